// File: rtl/cog_centroid_divider_if.sv
// Stream bundle for cog_centroid_divider: per-figure CoG beats in (no tready),
// backpressured centroid beats out. slave = divider view, master = environment view.
`timescale 1ns/1ps
interface cog_centroid_divider_if #(
    parameter int DATA_WIDTH = 8
);
    logic [8*DATA_WIDTH-1:0] s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tuser;
    logic                    s_axis_tlast;
    logic [31:0]             m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tuser;
    logic                    m_axis_tlast;
    logic                    m_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
    );
endinterface

// File: rtl/cog_centroid_divider.sv
// Centroid divider: FIFO-buffered CoG beats -> restoring divide -> Q11.FRAC_BITS centroid + row.
// Optional macro COG_DIV_ROUND_EN adds one quotient bit and rounds half up.
`timescale 1ns/1ps
module cog_centroid_divider #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_aresetn,
    cog_centroid_divider_if.slave  axis,
    output logic                   o_overflow
);

    localparam int IN_W = 8 * DATA_WIDTH;
`ifdef COG_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int NQ = 30 + FRAC_BITS + RND;
    localparam int SW = NQ + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(NQ);
    localparam int EW = 66;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_OUT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic [10:0]     row_q, row_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tvalid_q, tvalid_d;
    logic            tuser_q, tuser_d;
    logic            tlast_q, tlast_d;
    logic [31:0]     tdata_q, tdata_d;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [EW-1:0]   entry_q, entry_d;
    logic [NQ-1:0]   dvd_q, dvd_d;
    logic [22:0]     rem_q, rem_d;

    logic [IN_W-1:0] s_data;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic [23:0]     rem_shift;
    logic [23:0]     div_ext;
    logic            q_bit;
    logic [NQ-1:0]   quot;
    logic [15:0]     base;
    logic [SW-1:0]   sum;
    logic [10:0]     row_rep;

    function automatic logic [NQ-1:0] round_q(input logic [NQ-1:0] q);
`ifdef COG_DIV_ROUND_EN
        // q carries one guard bit below the LSB; adding it rounds half up
        return (q >> 1) + {{(NQ-1){1'b0}}, q[0]};
`else
        return q;
`endif
    endfunction

    function automatic logic [15:0] sat16(input logic [SW-1:0] v);
        return (|v[SW-1:16]) ? 16'hFFFF : v[15:0];
    endfunction

    assign s_data = axis.s_axis_tdata;

    // Restoring divide step and result assembly, shared by DIV and final cycle
    always_comb begin
        rem_shift = {rem_q, dvd_q[NQ-1]};
        div_ext   = {1'b0, entry_q[52:30]};
        q_bit     = (rem_shift >= div_ext);
        quot      = round_q({dvd_q[NQ-2:0], q_bit});
        base      = 16'(entry_q[63:53]) << FRAC_BITS;
        sum       = {{(SW-16){1'b0}}, base} + {1'b0, quot};
        row_rep   = entry_q[65] ? 11'd0 : row_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        tvalid_d = tvalid_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        entry_d  = entry_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;

        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = (state_q == S_IDLE) && !fifo_empty;
        // A full FIFO still takes the beat when the head leaves in the same cycle
        push       = axis.s_axis_tvalid && (!fifo_full || pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        ovf_d      = ovf_q | (axis.s_axis_tvalid & fifo_full & ~pop);

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    entry_d = mem_q[rd_ptr_q[AW-1:0]];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                dvd_d   = NQ'(entry_q[29:0]) << (FRAC_BITS + RND);
                rem_d   = '0;
                cnt_d   = CW'(NQ - 1);
                tuser_d = entry_q[65];
                tlast_d = entry_q[64];
                if (entry_q[52:30] == 23'd0) begin
                    tdata_d  = {1'b0, 4'b0, row_rep, 16'h0000};
                    tvalid_d = 1'b1;
                    state_d  = S_OUT;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                dvd_d = {dvd_q[NQ-2:0], q_bit};
                rem_d = q_bit ? 23'(rem_shift - div_ext) : rem_shift[22:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    tdata_d  = {1'b1, 4'b0, row_rep, sat16(sum)};
                    tvalid_d = 1'b1;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                if (axis.m_axis_tready) begin
                    tvalid_d = 1'b0;
                    row_d    = (tuser_q ? 11'd0 : row_q) + 11'(tlast_q);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            row_q    <= '0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
        end
    end

    // Storage and divider datapath need no reset; pointers and state guard them
    always_ff @(posedge i_sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {axis.s_axis_tuser, axis.s_axis_tlast, s_data[63:0]};
        end
        entry_q <= entry_d;
        dvd_q   <= dvd_d;
        rem_q   <= rem_d;
    end

    assign axis.m_axis_tdata  = tdata_q;
    assign axis.m_axis_tvalid = tvalid_q;
    assign axis.m_axis_tuser  = tuser_q;
    assign axis.m_axis_tlast  = tlast_q;
    assign o_overflow         = ovf_q;

endmodule

// File: tb/tb_cog_centroid_divider.sv
// Bench for cog_centroid_divider: directed and random beats checked against an
// arithmetic centroid model with a row tracker and an expected-result queue.
`timescale 1ns/1ps
module tb_cog_centroid_divider;

    localparam int FRAC = 5;
`ifdef COG_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int NDIV = 30 + FRAC + RND;

    typedef struct packed {
        logic [29:0] ixc;
        logic [22:0] si;
        logic [10:0] start;
        logic        tuser;
        logic        tlast;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ovf;
    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    beat_t       exp_q[$];
    logic [10:0] tb_row;

    cog_centroid_divider_if #(.DATA_WIDTH(8)) bus ();

    cog_centroid_divider #(
        .DATA_WIDTH(8),
        .FRAC_BITS (FRAC),
        .FIFO_DEPTH(16)
    ) dut (
        .i_sys_clk    (clk),
        .i_sys_aresetn(rst_n),
        .axis         (bus),
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input int ixc, input int si, input int start,
                                 input bit tuser, input bit tlast);
        beat_t b;
        b.ixc   = 30'(ixc);
        b.si    = 23'(si);
        b.start = 11'(start);
        b.tuser = tuser;
        b.tlast = tlast;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t       b;
        int unsigned mode;
        longint unsigned si, ixc;
        mode = $urandom_range(0, 9);
        b.start = 11'($urandom_range(0, 2047));
        b.tuser = ($urandom_range(0, 7) == 0);
        b.tlast = ($urandom_range(0, 3) == 0);
        if (mode == 0) begin
            b.si  = '0;
            b.ixc = 30'($urandom);
        end else if (mode == 1) begin
            b.si  = 23'($urandom_range(1, 3));
            b.ixc = 30'($urandom);
        end else begin
            si  = 64'($urandom_range(1, 8388607));
            ixc = si * 64'($urandom_range(0, 126)) + 64'($urandom_range(0, 32'(si - 1)));
            b.si  = 23'(si);
            b.ixc = 30'(ixc);
        end
        return b;
    endfunction

    // Centroid = start + sum_IxC/sum_I in Q11.FRAC, saturated to 16 bits
    function automatic logic [31:0] model_word(input beat_t b, input logic [10:0] row);
        longint unsigned num, den, q, r;
        if (b.si == 23'd0) return {5'b0, row, 16'h0000};
        num = 64'(b.ixc) << FRAC;
        den = 64'(b.si);
`ifdef COG_DIV_ROUND_EN
        q = (2 * num + den) / (2 * den);
`else
        q = num / den;
`endif
        r = (64'(b.start) << FRAC) + q;
        if (r > 64'd65535) r = 64'd65535;
        return {1'b1, 4'b0, row, r[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input beat_t b);
        @(negedge clk);
        bus.s_axis_tdata  = {b.start, b.si, b.ixc};
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tuser  = b.tuser;
        bus.s_axis_tlast  = b.tlast;
        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // lat = edge count from the push edge to the edge where tvalid is seen high
    task automatic wait_valid(input string tag, output int lat);
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            if (bus.m_axis_tvalid) begin
                lat = k + 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) check({tag, " timeout"}, 32'(bus.m_axis_tvalid), 32'd1);
    endtask

    task automatic expect_result(input string tag, input int stall,
                                 output logic [31:0] got, output int lat);
        beat_t       b;
        logic [31:0] exp;
        logic [10:0] rep;
        wait_valid(tag, lat);
        got = bus.m_axis_tdata;
        if (exp_q.size() == 0) begin
            check({tag, " unexpected"}, 32'(bus.m_axis_tvalid), 32'd0);
            return;
        end
        b   = exp_q.pop_front();
        rep = b.tuser ? 11'd0 : tb_row;
        exp = model_word(b, rep);
        check({tag, " tdata"}, bus.m_axis_tdata, exp);
        check({tag, " tuser"}, 32'(bus.m_axis_tuser), 32'(b.tuser));
        check({tag, " tlast"}, 32'(bus.m_axis_tlast), 32'(b.tlast));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold tdata"}, bus.m_axis_tdata, exp);
            check({tag, " hold tvalid"}, 32'(bus.m_axis_tvalid), 32'd1);
        end
        bus.m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_axis_tready = 1'b0;
        check({tag, " tvalid drop"}, 32'(bus.m_axis_tvalid), 32'd0);
        tb_row = rep + 11'(b.tlast);
    endtask

    initial begin : main
        logic [31:0] got;
        int          lat;
        int          seen;
        beat_t       b;

        rst_n             = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b0;
        tb_row            = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("reset tdata", bus.m_axis_tdata, 32'd0);
        check("reset tuser", 32'(bus.m_axis_tuser), 32'd0);
        check("reset tlast", 32'(bus.m_axis_tlast), 32'd0);
        check("reset overflow", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        b = mk(300, 100, 10, 1'b1, 1'b0);
        exp_q.push_back(b);
        send_beat(b);
        expect_result("t1", 0, got, lat);
        check("t1 word", got, 32'h8000_01A0);
        check("t1 latency", 32'(lat), 32'(NDIV + 3));

        b = mk(7, 3, 0, 1'b0, 1'b0);
        exp_q.push_back(b);
        send_beat(b);
        expect_result("t2", 0, got, lat);
`ifdef COG_DIV_ROUND_EN
        check("t2 word", got, 32'h8000_004B);
`else
        check("t2 word", got, 32'h8000_004A);
`endif
        check("t2 latency", 32'(lat), 32'(NDIV + 3));

        b = mk(12345, 0, 500, 1'b0, 1'b0);
        exp_q.push_back(b);
        send_beat(b);
        expect_result("t3 zero", 0, got, lat);
        check("t3 word", got, 32'h0000_0000);
        check("t3 latency", 32'(lat), 32'd3);

        b = mk(1000, 1, 2047, 1'b0, 1'b0);
        exp_q.push_back(b);
        send_beat(b);
        expect_result("sat", 0, got, lat);
        check("sat word", got, 32'h8000_FFFF);

        for (int i = 0; i < 24; i++) begin
            b = rand_beat();
            exp_q.push_back(b);
            send_beat(b);
            expect_result("rand", int'($urandom_range(0, 3)), got, lat);
        end

        for (int i = 1; i <= 20; i++) begin
            b = rand_beat();
            if (i <= 17) exp_q.push_back(b);
            send_beat(b);
            if (i == 17) check("ovf after 17", 32'(ovf), 32'd0);
            if (i == 18) check("ovf after 18", 32'(ovf), 32'd1);
        end
        for (int i = 0; i < 17; i++) expect_result("burst", 0, got, lat);
        seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.m_axis_tvalid) seen++;
        end
        check("burst extra results", 32'(seen), 32'd0);
        check("ovf sticky", 32'(ovf), 32'd1);

        b = mk(5000, 100, 20, 1'b1, 1'b1);
        exp_q.push_back(b);
        send_beat(b);
        expect_result("row a", 0, got, lat);
        check("row a field", 32'(got[26:16]), 32'd0);
        b = mk(777, 7, 30, 1'b0, 1'b1);
        exp_q.push_back(b);
        send_beat(b);
        expect_result("row b", 0, got, lat);
        check("row b field", 32'(got[26:16]), 32'd1);
        b = mk(4321, 55, 40, 1'b0, 1'b1);
        exp_q.push_back(b);
        send_beat(b);
        expect_result("row c", 0, got, lat);
        check("row c field", 32'(got[26:16]), 32'd2);
        b = mk(999, 9, 50, 1'b1, 1'b0);
        exp_q.push_back(b);
        send_beat(b);
        expect_result("row d", 10, got, lat);
        check("row d field", 32'(got[26:16]), 32'd0);

        send_beat(mk(300, 100, 10, 1'b0, 1'b0));
        send_beat(mk(600, 100, 10, 1'b0, 1'b0));
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("mid reset tdata", bus.m_axis_tdata, 32'd0);
        check("mid reset tuser", 32'(bus.m_axis_tuser), 32'd0);
        check("mid reset tlast", 32'(bus.m_axis_tlast), 32'd0);
        check("mid reset overflow", 32'(ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        tb_row = '0;
        seen   = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (bus.m_axis_tvalid) seen++;
        end
        check("post reset flushed", 32'(seen), 32'd0);

        b = mk(2500, 50, 100, 1'b0, 1'b0);
        exp_q.push_back(b);
        send_beat(b);
        expect_result("post reset", 0, got, lat);
        check("post reset latency", 32'(lat), 32'(NDIV + 3));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
